// File: rtl/herm_remover_param.sv
// Hermitian-symmetry remover: captures one FFT burst, compacts the active bins
// (lower half or mirrored+conjugated upper half) and serves them by random access.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_FILL    | accepting wren words into in_mem until IN_DEPTH words captured
// S_EXTRACT | streaming active bins from in_mem to out_mem (2-stage pipeline)
// S_READY   | out_mem complete; dout served from read_ptr
module herm_remover_param #(
   parameter  int DATA_W         = 16,
   parameter  int FFT_POINT      = 64,
   parameter  int ACTIVE_SUBCARR = 28,
   parameter  int SYMBOL_NUM     = 12,
   parameter  int FIRST_BIN      = 1,
   localparam int IN_DEPTH       = FFT_POINT * SYMBOL_NUM,
   localparam int OUT_DEPTH      = ACTIVE_SUBCARR * SYMBOL_NUM,
   localparam int IN_AW          = $clog2(IN_DEPTH),
   localparam int OUT_AW         = $clog2(OUT_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              wren,
   input  logic              tx_done,
   input  logic              mirror_sel,
   input  logic [OUT_AW-1:0] read_ptr,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              in_buff_full,
   output logic              out_buff_full,
   output logic              overflow
);

   localparam int HALF = DATA_W / 2;
   localparam int K    = ACTIVE_SUBCARR;
   localparam int KW   = (K > 1) ? $clog2(K) : 1;
   localparam int SW   = (SYMBOL_NUM > 1) ? $clog2(SYMBOL_NUM) : 1;

   typedef enum logic [1:0] {S_FILL, S_EXTRACT, S_READY} state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] in_mem  [IN_DEPTH];
   logic [DATA_W-1:0] out_mem [OUT_DEPTH];

   logic [IN_AW-1:0]  cnt_in;
   logic [SW-1:0]     sym;
   logic [KW-1:0]     k;
   logic [IN_AW-1:0]  sym_base_in;
   logic [OUT_AW-1:0] sym_base_out;
   logic              issue_done;
   logic              mirror_q;

   logic              accept, last_in, issue, last_issue;
   logic [IN_AW-1:0]  rd_addr;
   logic [OUT_AW-1:0] out_rd_addr;
   logic              ptr_in_range;
   int                bin_off;

   logic              v1, v2;
   logic [OUT_AW-1:0] wa1, wa2;
   logic [DATA_W-1:0] mem_q, dq, out_q;
   logic              ok1;

   // Imag negation; the most negative code has no positive twin, so clamp it.
   function automatic logic [DATA_W-1:0] conj(input logic [DATA_W-1:0] s);
      logic [HALF-1:0] im;
      im = s[HALF-1:0];
      if (im == {1'b1, {(HALF-1){1'b0}}})
         im = {1'b0, {(HALF-1){1'b1}}};
      else
         im = -im;
      return {s[DATA_W-1:HALF], im};
   endfunction

   assign accept       = (state == S_FILL) && wren && !tx_done;
   assign last_in      = (cnt_in == IN_AW'(IN_DEPTH - 1));
   assign issue        = (state == S_EXTRACT) && !issue_done;
   assign last_issue   = (sym == SW'(SYMBOL_NUM - 1)) && (k == KW'(K - 1));
   assign ptr_in_range = ({1'b0, read_ptr} < (OUT_AW + 1)'(OUT_DEPTH));
   assign out_rd_addr  = ptr_in_range ? read_ptr : '0;

   assign in_buff_full  = (state != S_FILL);
   assign out_buff_full = (state == S_READY);

   always_comb begin
      bin_off = mirror_q ? (FFT_POINT - FIRST_BIN - int'(k)) : (FIRST_BIN + int'(k));
      rd_addr = sym_base_in + IN_AW'(bin_off);
   end

   always_comb begin
      state_nxt = state;
      if (tx_done) begin
         state_nxt = S_FILL;
      end else begin
         case (state)
            S_FILL:    if (accept && last_in) state_nxt = S_EXTRACT;
            S_EXTRACT: if (v2 && (wa2 == OUT_AW'(OUT_DEPTH - 1))) state_nxt = S_READY;
            S_READY:   state_nxt = S_READY;
            default:   state_nxt = S_FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_in       <= '0;
         sym          <= '0;
         k            <= '0;
         sym_base_in  <= '0;
         sym_base_out <= '0;
         issue_done   <= 1'b0;
         mirror_q     <= 1'b0;
         overflow     <= 1'b0;
         v1           <= 1'b0;
         v2           <= 1'b0;
      end else if (tx_done) begin
         cnt_in       <= '0;
         sym          <= '0;
         k            <= '0;
         sym_base_in  <= '0;
         sym_base_out <= '0;
         issue_done   <= 1'b0;
         overflow     <= 1'b0;
         v1           <= 1'b0;
         v2           <= 1'b0;
      end else begin
         v1 <= issue;
         v2 <= v1;
         if (wren && (state != S_FILL)) overflow <= 1'b1;
         if (accept) begin
            cnt_in <= last_in ? '0 : cnt_in + IN_AW'(1);
            if (last_in) mirror_q <= mirror_sel;
         end
         if (issue) begin
            if (last_issue) begin
               sym          <= '0;
               k            <= '0;
               sym_base_in  <= '0;
               sym_base_out <= '0;
               issue_done   <= 1'b1;
            end else if (k == KW'(K - 1)) begin
               k            <= '0;
               sym          <= sym + SW'(1);
               sym_base_in  <= sym_base_in + IN_AW'(FFT_POINT);
               sym_base_out <= sym_base_out + OUT_AW'(K);
            end else begin
               k <= k + KW'(1);
            end
         end
      end
   end

   // Block-RAM style storage and extraction datapath; no reset on memory paths.
   always_ff @(posedge clk) begin
      if (accept) in_mem[cnt_in] <= din;
      mem_q <= in_mem[rd_addr];
      wa1   <= sym_base_out + OUT_AW'(k);
      wa2   <= wa1;
      dq    <= mirror_q ? conj(mem_q) : mem_q;
      if (v2) out_mem[wa2] <= dq;
      out_q <= out_mem[out_rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok1        <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         ok1 <= (state == S_READY) && ptr_in_range;
         if (tx_done) begin
            dout_valid <= 1'b0;
         end else if (state == S_READY) begin
            dout       <= ok1 ? out_q : '0;
            dout_valid <= ok1;
         end else begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_herm_remover_param.sv
// Bench for herm_remover_param: vector table, hand-written corner sequences and
// random reads checked against a bin-selection model of the compacted burst.
module tb_herm_remover_param;

   localparam int FP   = 64;
   localparam int K    = 28;
   localparam int SN   = 12;
   localparam int FB   = 1;
   localparam int IND  = FP * SN;
   localparam int OUTD = K * SN;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] din;
   logic        wren;
   logic        tx_done;
   logic        mirror_sel;
   logic [8:0]  read_ptr;
   logic [15:0] dout;
   logic        dout_valid;
   logic        in_buff_full;
   logic        out_buff_full;
   logic        overflow;

   herm_remover_param dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .din           (din),
      .wren          (wren),
      .tx_done       (tx_done),
      .mirror_sel    (mirror_sel),
      .read_ptr      (read_ptr),
      .dout          (dout),
      .dout_valid    (dout_valid),
      .in_buff_full  (in_buff_full),
      .out_buff_full (out_buff_full),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] ref_in [IND];
   bit          ref_mir;

   typedef struct {
      int          ptr;
      logic [15:0] d;
      bit          v;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Expected compacted word at output index idx, straight from the bin rules.
   function automatic logic [15:0] model_out(input int idx);
      int          s, kk, bin, im;
      logic [15:0] w;
      s   = idx / K;
      kk  = idx % K;
      bin = ref_mir ? (FP - FB - kk) : (FB + kk);
      w   = ref_in[s * FP + bin];
      if (!ref_mir) return w;
      im = int'($signed(w[7:0]));
      im = -im;
      if (im > 127) im = 127;
      return {w[15:8], 8'(im)};
   endfunction

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) begin
         wren = 1'b1;
         din  = ref_in[i];
         @(negedge clk);
      end
      wren = 1'b0;
   endtask

   task automatic pulse_tx();
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic wait_out_full(input string name, input int exp_cycles);
      int n;
      n = 0;
      while (!out_buff_full && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(n), 32'(exp_cycles));
   endtask

   // One address per cycle; each result is checked two cycles after issue.
   task automatic read_pipe(input string name, input int ptrs[$]);
      int n;
      int p;
      n = ptrs.size();
      for (int i = 0; i < n + 2; i++) begin
         if (i >= 2) begin
            p = ptrs[i-2];
            if (p >= OUTD) begin
               chk({name, "_dout"}, 32'(dout), 32'h0);
               chk({name, "_valid"}, 32'(dout_valid), 32'h0);
            end else begin
               chk({name, "_dout"}, 32'(dout), 32'(model_out(p)));
               chk({name, "_valid"}, 32'(dout_valid), 32'h1);
            end
         end
         if (i < n) read_ptr = 9'(ptrs[i]);
         @(negedge clk);
      end
   endtask

   task automatic random_reads(input string name, input int n);
      int q[$];
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, 380)));
      q.push_back(0);
      q.push_back(OUTD - 1);
      read_pipe(name, q);
   endtask

   task automatic rand_burst();
      for (int i = 0; i < IND; i++) ref_in[i] = 16'($urandom);
   endtask

   initial begin
      int q[$];
      logic [15:0] held;

      tbl[0] = '{ptr: 0,   d: 16'd1,   v: 1'b1};
      tbl[1] = '{ptr: 27,  d: 16'd28,  v: 1'b1};
      tbl[2] = '{ptr: 28,  d: 16'd65,  v: 1'b1};
      tbl[3] = '{ptr: 335, d: 16'd732, v: 1'b1};
      tbl[4] = '{ptr: 336, d: 16'd0,   v: 1'b0};
      tbl[5] = '{ptr: 511, d: 16'd0,   v: 1'b0};
      tbl[6] = '{ptr: 0,   d: 16'd1,   v: 1'b1};

      rst_n      = 1'b0;
      din        = '0;
      wren       = 1'b0;
      tx_done    = 1'b0;
      mirror_sel = 1'b0;
      read_ptr   = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_full",  32'(in_buff_full),  32'h0);
      chk("rst_out_full", 32'(out_buff_full), 32'h0);
      chk("rst_overflow", 32'(overflow),      32'h0);
      chk("rst_dout",     32'(dout),          32'h0);
      chk("rst_valid",    32'(dout_valid),    32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Address-valued burst, lower bins
      for (int i = 0; i < IND; i++) ref_in[i] = 16'(i);
      ref_mir = 1'b0;
      fill(IND);
      chk("a_in_full", 32'(in_buff_full), 32'h1);
      chk("a_out_full_early", 32'(out_buff_full), 32'h0);
      wait_out_full("a_extract_latency", 338);
      for (int i = 0; i < 9; i++) begin
         if (i >= 2) begin
            chk($sformatf("tbl%0d_dout", i-2), 32'(dout), 32'(tbl[i-2].d));
            chk($sformatf("tbl%0d_valid", i-2), 32'(dout_valid), 32'(tbl[i-2].v));
         end
         if (i < 7) read_ptr = 9'(tbl[i].ptr);
         @(negedge clk);
      end
      random_reads("a_rand", 40);

      // Mirrored burst with overflow pulses during EXTRACT and READY
      pulse_tx();
      rand_burst();
      ref_in[63] = 16'h0A05;
      ref_in[36] = 16'h0380;
      ref_mir    = 1'b1;
      mirror_sel = 1'b1;
      fill(IND);
      mirror_sel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wren = 1'b1;
         din  = 16'(~i);
         @(negedge clk);
      end
      wren = 1'b0;
      chk("m_overflow_extract", 32'(overflow), 32'h1);
      wait_out_full("m_extract_latency", 335);
      for (int i = 0; i < 2; i++) begin
         wren = 1'b1;
         din  = 16'hBEEF;
         @(negedge clk);
      end
      wren = 1'b0;
      chk("m_overflow_ready", 32'(overflow), 32'h1);
      q.delete();
      q.push_back(0);
      q.push_back(27);
      read_pipe("m_fixed", q);
      read_ptr = 9'd0;
      repeat (2) @(negedge clk);
      chk("m_conj", 32'(dout), 32'h0AFB);
      read_ptr = 9'd27;
      repeat (2) @(negedge clk);
      chk("m_conj_sat", 32'(dout), 32'h037F);
      random_reads("m_rand", 60);
      held = dout;
      pulse_tx();
      chk("m_tx_overflow", 32'(overflow),      32'h0);
      chk("m_tx_in_full",  32'(in_buff_full),  32'h0);
      chk("m_tx_out_full", 32'(out_buff_full), 32'h0);
      chk("m_tx_valid",    32'(dout_valid),    32'h0);
      chk("m_tx_dout_hold", 32'(dout), 32'(held));

      // tx_done coincident with wren after 300 words, then a full refill
      rand_burst();
      fill(300);
      wren    = 1'b1;
      tx_done = 1'b1;
      din     = 16'hDEAD;
      @(negedge clk);
      wren    = 1'b0;
      tx_done = 1'b0;
      chk("c_overflow", 32'(overflow),      32'h0);
      chk("c_in_full",  32'(in_buff_full),  32'h0);
      chk("c_out_full", 32'(out_buff_full), 32'h0);
      rand_burst();
      ref_mir = 1'b0;
      fill(IND);
      chk("c_in_full_after", 32'(in_buff_full), 32'h1);
      wait_out_full("c_extract_latency", 338);
      random_reads("c_rand", 40);

      // Reset pulse mid-EXTRACT, then a fresh mirrored burst
      pulse_tx();
      rand_burst();
      fill(IND);
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("r_in_full",  32'(in_buff_full),  32'h0);
      chk("r_out_full", 32'(out_buff_full), 32'h0);
      chk("r_overflow", 32'(overflow),      32'h0);
      chk("r_dout",     32'(dout),          32'h0);
      chk("r_valid",    32'(dout_valid),    32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      chk("r_no_partial_full", 32'(out_buff_full), 32'h0);
      rand_burst();
      ref_mir    = 1'b1;
      mirror_sel = 1'b1;
      fill(IND);
      wait_out_full("r_extract_latency", 338);
      random_reads("r_rand", 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/herm_remover_param.md
# herm_remover_param

Parametrised Hermitian-symmetry remover between the receive FFT output and the demapper. Captures one burst (`SYMBOL_NUM` symbols of `FFT_POINT` bins) into an input BRAM, then extracts `ACTIVE_SUBCARR` bins per symbol into an output BRAM. Extraction uses either the lower half-spectrum or the mirrored, conjugated upper half. The compacted burst is then served to the demapper by random-access `read_ptr` with a fixed latency.

## Interface
- `DATA_W`, 16, sample width; `din[DATA_W-1:DATA_W/2]` = real, `din[DATA_W/2-1:0]` = imag, both two's complement.
- `FFT_POINT`, 64, bins per symbol.
- `ACTIVE_SUBCARR`, 28, bins kept per symbol (K).
- `SYMBOL_NUM`, 12, symbols per burst (channel-estimation + data).
- `FIRST_BIN`, 1, first kept bin. Constraint: `FIRST_BIN + K <= FFT_POINT/2`.
- `IN_DEPTH` = `FFT_POINT*SYMBOL_NUM`; `OUT_DEPTH` = `K*SYMBOL_NUM`. Address widths are `$clog2` of each depth (derived, not overridable).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  DATA_W  FFT output sample.
- `wren`  in  1  `din` valid this cycle.
- `tx_done`  in  1  synchronous burst clear; highest priority after reset.
- `mirror_sel`  in  1  0 = lower bins; 1 = mirrored upper bins, conjugated. Sampled on entry to EXTRACT.
- `read_ptr`  in  OUT_AW  output buffer read address.
- `dout`  out  DATA_W  registered read data.
- `dout_valid`  out  1  `dout` corresponds to an in-range `read_ptr`.
- `in_buff_full`  out  1  burst capture complete.
- `out_buff_full`  out  1  extraction complete; `dout` is meaningful.
- `overflow`  out  1  sticky flag: a `wren` was dropped.

## Operation
- States: FILL → EXTRACT → READY. `tx_done` returns the FSM to FILL from any state.
- FILL
  - On each `wren`, write `din` to `in_mem[cnt_in]`, then `cnt_in++`.
  - When the write at `cnt_in = IN_DEPTH-1` occurs, set `in_buff_full=1` next cycle and go to EXTRACT.
- EXTRACT
  - Counters: `sym` 0..SYMBOL_NUM-1 and `k` 0..K-1. Issue one read per cycle, no gaps.
  - Read address, `mirror_sel=0`: `sym*FFT_POINT + FIRST_BIN + k`.
  - Read address, `mirror_sel=1`: `sym*FFT_POINT + FFT_POINT - FIRST_BIN - k`.
  - Write `out_mem[sym*K + k]`. When mirrored, the stored value has imag negated; `-(2^(W/2-1))` saturates to `2^(W/2-1)-1`. Real is unchanged.
  - After the final write: `out_buff_full=1`, go to READY.
- READY
  - `dout` ← `out_mem[read_ptr]`.
  - `read_ptr >= OUT_DEPTH` → `dout=0`, `dout_valid=0`.
  - `dout_valid=0` whenever `out_buff_full=0`.
- `wren` outside FILL: the word is dropped and `overflow` is set. `overflow` clears only on `tx_done` or reset.
- `tx_done`
  - Clears `cnt_in`, extraction counters, `in_buff_full`, `out_buff_full`, `overflow` and `dout_valid`. `dout` holds.
  - `wren` in the same cycle is ignored and does not set `overflow`.
  - BRAM contents are not cleared.
- Reset: all outputs 0, FSM in FILL, counters 0. Reset asserted mid-EXTRACT aborts extraction; no partial `out_buff_full`.

## Timing
- Input BRAM read latency is 1 cycle, and the read data is registered once before the output write, so the extraction pipeline depth is 2.
- EXTRACT entered at cycle t:
  - reads issued t .. t+OUT_DEPTH-1;
  - writes at t+2 .. t+OUT_DEPTH+1;
  - `out_buff_full` high at t+OUT_DEPTH+2 (defaults: t+338).
- Capture: `in_buff_full` rises the cycle after the IN_DEPTH-th accepted `wren`. Back-to-back `wren` is supported.
- Read path: latency 2 (BRAM register + output register). `read_ptr` at edge n gives `dout`/`dout_valid` after edge n+2. Fully pipelined: one address per cycle.
- No backpressure. The upstream must stop `wren` after `in_buff_full`; any excess is flagged via `overflow`.

## Test plan
- Defaults, `mirror_sel=0`, 768 `wren` with `din` = address, then `read_ptr` = 0, 27, 28, 335 → `dout` = 1, 28, 65, 732 with `dout_valid=1`. `out_buff_full` rises 338 cycles after `in_buff_full`.
- `mirror_sel=1`, symbol-0 bin 63 = 0x0A05, bin 36 = 0x0380 → `read_ptr` 0 gives 0x0AFB; `read_ptr` 27 gives 0x037F (saturated).
- `wren` pulses during EXTRACT and during READY → `overflow=1`; output contents are identical to the clean run; `tx_done` clears `overflow`.
- `tx_done` after 300 words, coincident with `wren` → flags 0, that word dropped, no `overflow`. A full 768-word refill then produces the correct output.
- `rst_n` low for 1 cycle mid-EXTRACT → all outputs 0 immediately. A fresh burst afterwards completes normally.
- `read_ptr` = 336 and 511 in READY → `dout=0`, `dout_valid=0`. `read_ptr` = 0 in the next cycle → valid data after 2 cycles.
